// File: rtl/arm_pkg.sv
// Shared word-level types for the fetch/decode boundary.
// An IF/ID entry is one {PC, instruction} pair as handed from fetch to decode.
package arm_pkg;

  localparam int WORD_W        = 32;
  localparam int IF_ID_ENTRY_W = 2 * WORD_W;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } if_id_entry_t;

  function automatic if_id_entry_t pack_entry(input logic [WORD_W-1:0] pc,
                                              input logic [WORD_W-1:0] instr);
    if_id_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    return e;
  endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode boundary bundle: IF word + flush in, freeze back to IF, head entry out to ID.
// master = pipeline side driving fetch words and id_ready; slave = the queue.
interface if_id_queue_if
  import arm_pkg::*;
#(
  parameter int AW = 2
);

  logic [WORD_W-1:0] PC_in;
  logic [WORD_W-1:0] Instruction_in;
  logic              Branch_taken;
  logic              freeze;
  logic              id_ready;
  logic              valid;
  logic [WORD_W-1:0] PC;
  logic [WORD_W-1:0] Instruction;
  logic [AW:0]       count;

  modport master (
    output PC_in, Instruction_in, Branch_taken, id_ready,
    input  freeze, valid, PC, Instruction, count
  );

  modport slave (
    input  PC_in, Instruction_in, Branch_taken, id_ready,
    output freeze, valid, PC, Instruction, count
  );

endinterface

// File: rtl/if_id_queue_mem.sv
// DEPTH x entry register file, one synchronous write port and one asynchronous read port.
// Storage is never reset; the owning queue's count decides which slots are meaningful.
module if_id_queue_mem
  import arm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic [IF_ID_ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]            raddr_i,
  output logic [IF_ID_ENTRY_W-1:0] rdata_o
);

  logic [IF_ID_ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH entries, 1-cycle fill latency, freeze to IF when full, flush on Branch_taken.
// Optional zero-latency empty-queue bypass when IF_ID_QUEUE_BYPASS_EN is defined.
module if_id_queue
  import arm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  q_if
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;

  logic         flush, empty, full, freeze;
  logic         enq, wr_en, deq;
  logic         byp_vld, byp_take;
  if_id_entry_t wr_entry, rd_entry;

  assign flush  = q_if.Branch_taken;
  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  // Built from registered count only, so freeze never depends on id_ready.
  assign freeze = full & ~flush;
  assign enq    = ~freeze & ~flush;
  assign deq    = ~empty & q_if.id_ready & ~flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign byp_vld  = empty & ~flush & ~freeze & ~rst;
  assign byp_take = byp_vld & q_if.id_ready;
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;
`endif

  // A bypassed word consumed by ID this cycle must not also land in storage.
  assign wr_en    = enq & ~byp_take;
  assign wr_entry = pack_entry(q_if.PC_in, q_if.Instruction_in);

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (deq)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({wr_en, deq})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    q_if.valid       = 1'b0;
    q_if.PC          = '0;
    q_if.Instruction = NOP_INSTR;
    if (byp_vld) begin
      q_if.valid       = 1'b1;
      q_if.PC          = q_if.PC_in;
      q_if.Instruction = q_if.Instruction_in;
    end else if (!empty) begin
      q_if.valid       = 1'b1;
      q_if.PC          = rd_entry.pc;
      q_if.Instruction = rd_entry.instr;
    end
  end

  assign q_if.freeze = freeze;
  assign q_if.count  = count_q;

endmodule
